// File: rtl/instr_decode_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle for instr_decode.
// The fetch/execute side drives through master; the decoder sits on slave.
interface instr_decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            in_ready;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_funct3;
  logic            out_funct7b5;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_class;
  logic            out_illegal;
  logic            halted;
  logic [31:0]     dec_count;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
    input  out_funct7b5, out_imm, out_class, out_illegal, halted, dec_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_funct3,
    output out_funct7b5, out_imm, out_class, out_illegal, halted, dec_count
  );
endinterface

// File: rtl/instr_decode.sv
// Single-register RV32 decode stage: classifies the opcode, extracts register
// fields and the immediate, and tracks halt and completed-handshake count.
module instr_decode #(
  parameter int unsigned XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  instr_decode_if.slave bus
);

  localparam logic [3:0] ClsNone   = 4'd0;
  localparam logic [3:0] ClsLui    = 4'd1;
  localparam logic [3:0] ClsAuipc  = 4'd2;
  localparam logic [3:0] ClsJal    = 4'd3;
  localparam logic [3:0] ClsJalr   = 4'd4;
  localparam logic [3:0] ClsBranch = 4'd5;
  localparam logic [3:0] ClsLoad   = 4'd6;
  localparam logic [3:0] ClsStore  = 4'd7;
  localparam logic [3:0] ClsOpImm  = 4'd8;
  localparam logic [3:0] ClsOp     = 4'd9;
  localparam logic [3:0] ClsSystem = 4'd10;

  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [31:0]     count_q, count_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rd_q, rd_d;
  logic [4:0]      rs1_q, rs1_d;
  logic [4:0]      rs2_q, rs2_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7b5_q, funct7b5_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [3:0]      class_q, class_d;
  logic            illegal_q, illegal_d;

  logic [31:0]     instr;
  logic [3:0]      dec_class;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic            is_halt;
  logic            in_ready;
  logic            accept;
  logic            out_hs;

  assign instr    = bus.in_instr;
  assign is_halt  = (instr == 32'h0000_0000) || (instr == 32'h0000_0073);
  assign in_ready = (!valid_q || bus.out_ready) && !halted_q && !bus.flush;
  assign accept   = bus.in_valid && in_ready;
  // A flush discards the held entry, so it never counts as a delivery.
  assign out_hs   = valid_q && bus.out_ready && !bus.flush;

  always_comb begin
    dec_class   = ClsNone;
    dec_illegal = 1'b0;
    unique case (instr[6:0])
      7'b0110111: dec_class = ClsLui;
      7'b0010111: dec_class = ClsAuipc;
      7'b1101111: dec_class = ClsJal;
      7'b1100111: dec_class = ClsJalr;
      7'b1100011: dec_class = ClsBranch;
      7'b0000011: dec_class = ClsLoad;
      7'b0100011: dec_class = ClsStore;
      7'b0010011: dec_class = ClsOpImm;
      7'b0110011: dec_class = ClsOp;
      7'b1110011: dec_class = ClsSystem;
      default:    dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    dec_imm = '0;
    unique case (dec_class)
      ClsJalr, ClsLoad, ClsOpImm, ClsSystem:
        dec_imm = {{20{instr[31]}}, instr[31:20]};
      ClsStore:
        dec_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ClsBranch:
        dec_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ClsLui, ClsAuipc:
        dec_imm = {instr[31:12], 12'b0};
      ClsJal:
        dec_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        dec_imm = '0;
    endcase
  end

  always_comb begin
    valid_d    = valid_q;
    halted_d   = halted_q;
    count_d    = count_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    imm_d      = imm_q;
    class_d    = class_q;
    illegal_d  = illegal_q;

    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      halted_d   = halted_q | is_halt;
      pc_d       = bus.in_pc;
      rd_d       = instr[11:7];
      rs1_d      = instr[19:15];
      rs2_d      = instr[24:20];
      funct3_d   = instr[14:12];
      funct7b5_d = instr[30];
      imm_d      = dec_imm;
      class_d    = dec_class;
      illegal_d  = dec_illegal;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end

    if (out_hs) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      count_q    <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      imm_q      <= '0;
      class_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
      imm_q      <= imm_d;
      class_q    <= class_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_rs1      = rs1_q;
  assign bus.out_rs2      = rs2_q;
  assign bus.out_funct3   = funct3_q;
  assign bus.out_funct7b5 = funct7b5_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_class    = class_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.halted       = halted_q;
  assign bus.dec_count    = count_q;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios plus a randomized
// stream checked against a transaction-level reference model.
module tb_instr_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        ill;
  } dec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  instr_decode_if #(.XLEN(32)) bus ();

  instr_decode #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference decode from the ISA field rules, using arithmetic shifts/sums.
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    logic [6:0]  ops [10];
    logic [31:0] sg;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    d.pc = pc; d.rd = ins[11:7]; d.rs1 = ins[19:15]; d.rs2 = ins[24:20];
    d.f3 = ins[14:12]; d.f7 = ins[30]; d.cls = 4'd0; d.ill = 1'b1; d.imm = 32'd0;
    for (int i = 0; i < 10; i++) begin
      if (ins[6:0] == ops[i]) begin
        d.cls = 4'(i + 1);
        d.ill = 1'b0;
      end
    end
    sg = ins[31] ? 32'hFFFF_FFFF : 32'd0;
    case (d.cls)
      4'd4, 4'd6, 4'd8, 4'd10: d.imm = 32'($signed(ins) >>> 20);
      4'd7: d.imm = 32'(($signed(ins) >>> 25) * 32) + 32'(ins[11:7]);
      4'd5: d.imm = (sg << 12) + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32
                    + 32'(ins[11:8]) * 2;
      4'd1, 4'd2: d.imm = ins & 32'hFFFF_F000;
      4'd3: d.imm = (sg << 20) + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048
                    + 32'(ins[30:21]) * 2;
      default: d.imm = 32'd0;
    endcase
    return d;
  endfunction

  function automatic dec_t observe();
    dec_t d;
    d.pc = bus.out_pc; d.rd = bus.out_rd; d.rs1 = bus.out_rs1; d.rs2 = bus.out_rs2;
    d.f3 = bus.out_funct3; d.f7 = bus.out_funct7b5; d.imm = bus.out_imm;
    d.cls = bus.out_class; d.ill = bus.out_illegal;
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] w;
    int          k;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 10) w[6:0] = ops[k];
    if (w == 32'h0 || w == 32'h73) w = 32'h0000_0013;
    return w;
  endfunction

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    dec_t zero;
    zero = '0;
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.halted !== 1'b0 || bus.dec_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_ctrl: got valid=%b halted=%b count=%h, want 0/0/0",
               bus.out_valid, bus.halted, bus.dec_count);
    end
    total++;
    if (observe() !== zero) begin
      bad++;
      $display("FAIL reset_fields: got %h, want %h", observe(), zero);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'h0; bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd8 || bus.out_imm !== 32'd5 ||
        bus.out_rd !== 5'd1) begin
      bad++;
      $display("FAIL b2b_first: got v=%b cls=%0d imm=%h rd=%0d, want 1/8/5/1",
               bus.out_valid, bus.out_class, bus.out_imm, bus.out_rd);
    end
    bus.in_instr = 32'h0020_8133; bus.in_pc = 32'h4;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: got %b, want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_class !== 4'd9 || bus.out_rs1 !== 5'd1 ||
        bus.out_rs2 !== 5'd2 || bus.out_rd !== 5'd2 || bus.out_pc !== 32'h4 ||
        bus.dec_count !== 32'd1) begin
      bad++;
      $display("FAIL b2b_second: got v=%b cls=%0d rs1=%0d rs2=%0d rd=%0d pc=%h cnt=%0d",
               bus.out_valid, bus.out_class, bus.out_rs1, bus.out_rs2, bus.out_rd,
               bus.out_pc, bus.dec_count);
    end
    @(negedge clk);
    total++;
    if (bus.dec_count !== 32'd2 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_count: got cnt=%0d v=%b, want 2/0", bus.dec_count, bus.out_valid);
    end
  endtask

  task automatic test_stall();
    dec_t        exp;
    logic [31:0] cnt0;
    do_reset();
    exp = ref_decode(32'hFE00_0EE3, 32'h100);
    bus.in_valid = 1'b1; bus.in_instr = 32'hFE00_0EE3; bus.in_pc = 32'h100;
    @(negedge clk);
    cnt0 = bus.dec_count;
    bus.in_instr = 32'h0050_0093;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || observe() !== exp ||
          bus.out_class !== 4'd5 || bus.dec_count !== cnt0) begin
        bad++;
        $display("FAIL stall_%0d: got rdy=%b v=%b fields=%h cnt=%0d, want 0/1/%h/%0d", c,
                 bus.in_ready, bus.out_valid, observe(), bus.dec_count, exp, cnt0);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_immediates();
    logic [31:0] words [4];
    logic [31:0] want  [4];
    logic [31:0] w;
    dec_t        exp;
    words = '{32'h1234_50B7, 32'hFFDF_F06F, 32'hFE11_2E23, 32'h0000_007F};
    want  = '{32'h1234_5000, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      w = (i < 4) ? words[i] : rand_instr();
      exp = ref_decode(w, 32'(i * 4));
      bus.in_valid = 1'b1; bus.in_instr = w; bus.in_pc = 32'(i * 4);
      @(negedge clk);
      bus.in_valid = 1'b0;
      total++;
      if (observe() !== exp || (i < 4 && bus.out_imm !== want[i]) ||
          (i == 3 && (bus.out_illegal !== 1'b1 || bus.out_class !== 4'd0))) begin
        bad++;
        $display("FAIL imm_%0d instr=%h: got %h, want %h", i, w, observe(), exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush();
    logic [31:0] cnt0;
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'h20;
    @(negedge clk);
    cnt0 = bus.dec_count;
    bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_instr = 32'h0020_8133;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready: got %b, want 0", bus.in_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.dec_count !== cnt0 || bus.halted !== 1'b0) begin
      bad++;
      $display("FAIL flush_effect: got v=%b cnt=%0d halted=%b, want 0/%0d/0",
               bus.out_valid, bus.dec_count, cnt0, bus.halted);
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0000_0073; bus.in_pc = 32'h40;
    @(negedge clk);
    bus.in_instr = 32'h0050_0093; bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.halted !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_class !== 4'd10 ||
        bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL halt_set: got h=%b v=%b cls=%0d rdy=%b, want 1/1/10/0",
               bus.halted, bus.out_valid, bus.out_class, bus.in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.dec_count !== 32'd1 || bus.in_ready !== 1'b0 ||
        bus.halted !== 1'b1) begin
      bad++;
      $display("FAIL halt_hold: got v=%b cnt=%0d rdy=%b h=%b, want 0/1/0/1",
               bus.out_valid, bus.dec_count, bus.in_ready, bus.halted);
    end
    do_reset();
    #1;
    total++;
    if (bus.halted !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL halt_reset: got h=%b rdy=%b, want 0/1", bus.halted, bus.in_ready);
    end
  endtask

  task automatic test_wrap_reset();
    dec_t zero;
    zero = '0;
    do_reset();
    bus.in_valid = 1'b1; bus.in_instr = 32'h0050_0093; bus.in_pc = 32'h8;
    @(negedge clk);
    bus.in_valid = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    total++;
    if (bus.dec_count !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h, want ffffffff", bus.dec_count);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.dec_count !== 32'd0) begin
      bad++;
      $display("FAIL wrap: got %h, want 0", bus.dec_count);
    end
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 32'hFFDF_F06F;
    @(negedge clk);
    bus.in_instr = 32'h0000_0073; bus.out_ready = 1'b1; bus.flush = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (observe() !== zero || bus.out_valid !== 1'b0 || bus.halted !== 1'b0 ||
        bus.dec_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: got v=%b h=%b cnt=%0d fields=%h, want all 0",
               bus.out_valid, bus.halted, bus.dec_count, observe());
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  // Random traffic against a one-entry transaction model with a delivery count.
  task automatic test_random();
    dec_t        m_ent;
    logic        m_val;
    logic [31:0] m_cnt;
    logic        exp_rdy;
    logic        acc;
    logic        hs;
    do_reset();
    m_val = 1'b0; m_cnt = 32'd0; m_ent = '0;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = (!m_val || bus.out_ready) && !bus.flush;
      total++;
      if (bus.in_ready !== exp_rdy || bus.out_valid !== m_val || bus.dec_count !== m_cnt ||
          (m_val && observe() !== m_ent)) begin
        bad++;
        $display("FAIL rand_%0d: got rdy=%b v=%b cnt=%0d f=%h, want %b/%b/%0d/%h", c,
                 bus.in_ready, bus.out_valid, bus.dec_count, observe(),
                 exp_rdy, m_val, m_cnt, m_ent);
      end
      acc = bus.in_valid && exp_rdy;
      hs  = m_val && bus.out_ready && !bus.flush;
      if (hs) m_cnt = m_cnt + 1;
      if (bus.flush) m_val = 1'b0;
      else if (acc) begin
        m_val = 1'b1;
        m_ent = ref_decode(bus.in_instr, bus.in_pc);
      end else if (hs) m_val = 1'b0;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_stall();
    test_immediates();
    test_flush();
    test_random();
    test_halt();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
